// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI RAM back-end: command encodings, FSM states
// and a depth helper used by the memory array.
package spi_ram_pkg;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    HOLD  = 2'b10
  } state_t;

  function automatic int unsigned depth_of(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/spi_ram_mem.sv
// DEPTH x DATA_WIDTH word store, one write port, one registered read port.
// Build option: SPI_RAM_CLEAR_ON_RESET_EN zeroes the whole array on reset.
module spi_ram_mem
  import spi_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = int'(depth_of(ADDR_WIDTH));

  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_reg;

`ifdef SPI_RAM_CLEAR_ON_RESET_EN
  // Flop-based array so every word can be cleared by the reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end
`endif

  // The read register doubles as the transmit data register, so it must
  // drop to zero on reset even though the array itself is not cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_reg <= '0;
    end else if (rd_en) begin
      rd_data_reg <= mem_reg[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/spi_ram_ctrl.sv
// SPI RAM back-end: command decode, write/read pointers with wrap,
// burst counter and tx_valid/tx_ready handshake towards the transmitter.
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [DATA_WIDTH+1:0] din,
  input  logic                  tx_ready,
  output logic                  tx_valid,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  busy
);

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] write_add_reg, write_add_next;
  logic [ADDR_WIDTH-1:0] read_add_reg, read_add_next;
  logic [ADDR_WIDTH-1:0] remain_reg, remain_next;
  logic                  tx_valid_reg, tx_valid_next;
  logic                  wr_en, rd_en;

  cmd_t                  cmd;
  logic [DATA_WIDTH-1:0] payload;
  logic [ADDR_WIDTH-1:0] field;

  assign cmd     = cmd_t'(din[DATA_WIDTH+1:DATA_WIDTH]);
  assign payload = din[DATA_WIDTH-1:0];
  assign field   = payload[ADDR_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      write_add_reg <= '0;
      read_add_reg  <= '0;
      remain_reg    <= '0;
      tx_valid_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      write_add_reg <= write_add_next;
      read_add_reg  <= read_add_next;
      remain_reg    <= remain_next;
      tx_valid_reg  <= tx_valid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    write_add_next = write_add_reg;
    read_add_next  = read_add_reg;
    remain_next    = remain_reg;
    tx_valid_next  = tx_valid_reg;
    wr_en          = 1'b0;
    rd_en          = 1'b0;

    case (state_reg)
      IDLE: begin
        // Commands are only decoded here, which is what drops them mid-burst.
        if (rx_valid) begin
          case (cmd)
            CMD_WR_ADDR: write_add_next = field;
            CMD_WR_DATA: begin
              wr_en          = 1'b1;
              write_add_next = write_add_reg + ADDR_WIDTH'(1);
            end
            CMD_RD_ADDR: read_add_next = field;
            CMD_RD_DATA: begin
              remain_next = field;
              state_next  = FETCH;
            end
            default: ;
          endcase
        end
      end
      FETCH: begin
        rd_en         = 1'b1;
        read_add_next = read_add_reg + ADDR_WIDTH'(1);
        tx_valid_next = 1'b1;
        state_next    = HOLD;
      end
      HOLD: begin
        if (tx_ready) begin
          if (remain_reg != '0) begin
            rd_en         = 1'b1;
            read_add_next = read_add_reg + ADDR_WIDTH'(1);
            remain_next   = remain_reg - ADDR_WIDTH'(1);
          end else begin
            tx_valid_next = 1'b0;
            state_next    = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  spi_ram_mem #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mem (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_addr(write_add_reg),
    .wr_data(payload),
    .rd_en  (rd_en),
    .rd_addr(read_add_reg),
    .rd_data(dout)
  );

  assign tx_valid = tx_valid_reg;
  assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl: a command/expected-word table for the
// 8-bit build, hand sequences for handshake corner cases and a 4/16 build.
module tb_spi_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        rx_valid = 1'b0;
  logic [9:0]  din = '0;
  logic        tx_ready = 1'b0;
  logic        tx_valid;
  logic [7:0]  dout;
  logic        busy;

  logic        rx_valid16 = 1'b0;
  logic [17:0] din16 = '0;
  logic        tx_ready16 = 1'b0;
  logic        tx_valid16;
  logic [15:0] dout16;
  logic        busy16;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spi_ram_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .din(din),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .dout(dout), .busy(busy)
  );

  spi_ram_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .rx_valid(rx_valid16), .din(din16),
    .tx_ready(tx_ready16), .tx_valid(tx_valid16), .dout(dout16), .busy(busy16)
  );

  typedef struct {
    logic [1:0]      cmd;
    logic [7:0]      payload;
    int              n;
    logic [3:0][7:0] exp;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [1:0] cmd, input logic [7:0] payload);
    @(negedge clk);
    rx_valid = 1'b1;
    din      = {cmd, payload};
    @(negedge clk);
    rx_valid = 1'b0;
    $display("cmd %b payload %02h busy_after=%0b", cmd, payload, busy);
  endtask

  task automatic send16(input logic [1:0] cmd, input logic [15:0] payload);
    @(negedge clk);
    rx_valid16 = 1'b1;
    din16      = {cmd, payload};
    @(negedge clk);
    rx_valid16 = 1'b0;
    $display("w16 cmd %b payload %04h", cmd, payload);
  endtask

  // Called right after a CMD_RD_DATA; checks latency, words and burst end.
  task automatic read_burst(input int n, input logic [3:0][7:0] exp, input string name);
    int t;
    t = 0;
    check({name, " busy at fetch"}, {31'd0, busy}, 32'd1);
    check({name, " tx_valid at fetch"}, {31'd0, tx_valid}, 32'd0);
    tx_ready = 1'b1;
    while (!tx_valid && t < 8) begin
      @(negedge clk);
      t++;
    end
    check({name, " first word latency"}, t, 1);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s word%0d tx_valid", name, i), {31'd0, tx_valid}, 32'd1);
      check($sformatf("%s word%0d dout", name, i), {24'd0, dout}, {24'd0, exp[i]});
      $display("  %s word %0d dout=%02h", name, i, dout);
      @(negedge clk);
    end
    check({name, " tx_valid after"}, {31'd0, tx_valid}, 32'd0);
    check({name, " busy after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{2'b00, 8'h40, 0, 32'h0};
    vecs[1]  = '{2'b01, 8'h44, 0, 32'h0};
    vecs[2]  = '{2'b00, 8'h10, 0, 32'h0};
    vecs[3]  = '{2'b01, 8'hA1, 0, 32'h0};
    vecs[4]  = '{2'b01, 8'hB2, 0, 32'h0};
    vecs[5]  = '{2'b01, 8'hC3, 0, 32'h0};
    vecs[6]  = '{2'b01, 8'hD4, 0, 32'h0};
    vecs[7]  = '{2'b10, 8'h10, 0, 32'h0};
    vecs[8]  = '{2'b11, 8'h00, 1, 32'h000000A1};
    vecs[9]  = '{2'b11, 8'h00, 1, 32'h000000B2};
    vecs[10] = '{2'b11, 8'h00, 1, 32'h000000C3};
    vecs[11] = '{2'b10, 8'h10, 0, 32'h0};
    vecs[12] = '{2'b11, 8'h03, 4, 32'hD4C3B2A1};
    vecs[13] = '{2'b00, 8'hFF, 0, 32'h0};
    vecs[14] = '{2'b01, 8'h11, 0, 32'h0};
    vecs[15] = '{2'b01, 8'h22, 0, 32'h0};
    vecs[16] = '{2'b01, 8'h33, 0, 32'h0};
    vecs[17] = '{2'b10, 8'hFF, 0, 32'h0};
    vecs[18] = '{2'b11, 8'h01, 2, 32'h00002211};
    vecs[19] = '{2'b11, 8'h00, 1, 32'h00000033};

    repeat (2) @(negedge clk);
    check("reset tx_valid", {31'd0, tx_valid}, 32'd0);
    check("reset dout", {24'd0, dout}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset tx_valid16", {31'd0, tx_valid16}, 32'd0);
    check("reset dout16", {16'd0, dout16}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 20; i++) begin
      send(vecs[i].cmd, vecs[i].payload);
      if (vecs[i].n > 0) read_burst(vecs[i].n, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Backpressure: word 2 stalled for three cycles.
    send(2'b10, 8'h10);
    tx_ready = 1'b0;
    send(2'b11, 8'h03);
    tx_ready = 1'b1;
    @(negedge clk);
    check("bp word0", {24'd0, dout}, 32'hA1);
    @(negedge clk);
    check("bp word1", {24'd0, dout}, 32'hB2);
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("bp hold%0d dout", i), {24'd0, dout}, 32'hB2);
      check($sformatf("bp hold%0d tx_valid", i), {31'd0, tx_valid}, 32'd1);
    end
    tx_ready = 1'b1;
    @(negedge clk);
    check("bp word2", {24'd0, dout}, 32'hC3);
    @(negedge clk);
    check("bp word3", {24'd0, dout}, 32'hD4);
    @(negedge clk);
    check("bp end tx_valid", {31'd0, tx_valid}, 32'd0);
    check("bp end busy", {31'd0, busy}, 32'd0);

    // Command issued mid-burst must be dropped.
    send(2'b00, 8'h50);
    send(2'b01, 8'h5A);
    send(2'b10, 8'h50);
    tx_ready = 1'b0;
    send(2'b11, 8'h00);
    @(negedge clk);
    check("drop hold dout", {24'd0, dout}, 32'h5A);
    send(2'b00, 8'h40);
    check("drop busy", {31'd0, busy}, 32'd1);
    check("drop dout stable", {24'd0, dout}, 32'h5A);
    tx_ready = 1'b1;
    @(negedge clk);
    check("drop end busy", {31'd0, busy}, 32'd0);
    send(2'b01, 8'h77);
    send(2'b10, 8'h51);
    send(2'b11, 8'h00);
    read_burst(1, 32'h77, "drop wr_add kept");
    send(2'b10, 8'h40);
    send(2'b11, 8'h00);
    read_burst(1, 32'h44, "drop 0x40 intact");

    // 4-bit address / 16-bit data: full-depth burst wraps to its start.
    send16(2'b00, 16'h0000);
    for (int i = 0; i < 16; i++) send16(2'b01, 16'hA500 + 16'(i) * 16'h0101);
    send16(2'b10, 16'h0000);
    send16(2'b11, 16'h000F);
    tx_ready16 = 1'b1;
    begin
      int t;
      t = 0;
      while (!tx_valid16 && t < 8) begin
        @(negedge clk);
        t++;
      end
      check("w16 first word latency", t, 1);
    end
    for (int i = 0; i < 16; i++) begin
      check($sformatf("w16 word%0d", i), {16'd0, dout16}, {16'd0, 16'hA500 + 16'(i) * 16'h0101});
      @(negedge clk);
    end
    check("w16 end tx_valid", {31'd0, tx_valid16}, 32'd0);
    check("w16 end busy", {31'd0, busy16}, 32'd0);
    send16(2'b11, 16'h0000);
    tx_ready16 = 1'b1;
    @(negedge clk);
    check("w16 read_add wrapped", {16'd0, dout16}, 32'hA500);

    // Asynchronous reset in the middle of a burst.
    send(2'b10, 8'h10);
    tx_ready = 1'b0;
    send(2'b11, 8'h03);
    @(negedge clk);
    check("rst pre tx_valid", {31'd0, tx_valid}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rst async tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst async busy", {31'd0, busy}, 32'd0);
    check("rst async dout", {24'd0, dout}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    send(2'b11, 8'h00);
`ifdef SPI_RAM_CLEAR_ON_RESET_EN
    read_burst(1, 32'h00, "post-rst addr0");
`else
    read_burst(1, 32'h22, "post-rst addr0");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_ram_ctrl.md
# spi_ram_ctrl

- Parametrised memory back-end for the SPI slave.
- Decodes the same 2-bit command + payload words from the SPI receiver.
- Adds four things: configurable address/data width, write-address auto-increment, burst reads of up to 2^ADDR_WIDTH words, and a tx_valid/tx_ready handshake towards the SPI transmitter.
- Sits between the SPI slave's receive path (rx_valid/din) and transmit path (tx_valid/dout/tx_ready).

## Interface
Parameters:
- ADDR_WIDTH, 8, address bits; DEPTH = 2**ADDR_WIDTH words. Must satisfy ADDR_WIDTH <= DATA_WIDTH.
- DATA_WIDTH, 8, memory word width and command payload width.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rx_valid  in  1  din holds a complete command word this cycle.
- din  in  DATA_WIDTH+2  [DATA_WIDTH+1:DATA_WIDTH] = command, [DATA_WIDTH-1:0] = payload.
- tx_ready  in  1  transmitter has consumed dout this cycle.
- tx_valid  out  1  dout holds a read word; held until tx_ready.
- dout  out  DATA_WIDTH  read data.
- busy  out  1  burst read in progress; rx_valid is ignored while high.

## Operation
Commands are accepted only when rx_valid=1 and busy=0:
- 00: write_add <= payload[ADDR_WIDTH-1:0].
- 01: mem[write_add] <= payload; write_add <= write_add+1, wrapping DEPTH-1 -> 0.
- 10: read_add <= payload[ADDR_WIDTH-1:0].
- 11: burst read of payload[ADDR_WIDTH-1:0]+1 words, starting at read_add.
  - A payload of 0 gives a single word, which keeps the old single-read behaviour.

FSM states:
- IDLE: busy=0, tx_valid=0. Command 11 loads remain <= length field and goes to FETCH.
- FETCH: dout <= mem[read_add], tx_valid <= 1, read_add++ (wraps), goes to HOLD. busy=1.
- HOLD: tx_valid=1, dout stable.
  - tx_ready=1 and remain != 0: remain--, dout <= mem[read_add], read_add++; stay in HOLD.
  - tx_ready=1 and remain == 0: tx_valid <= 0; go to IDLE.
  - tx_ready=0: hold all state.

Boundary rules:
- After a burst, read_add points one past the last word read (wrapped), so a second 11 continues sequentially.
- A burst longer than DEPTH is impossible; a full-DEPTH burst wraps back to the start address.
- rx_valid while busy=1: the command is dropped, with no state change. The SPI master must not issue commands mid-burst.
- tx_ready while tx_valid=0: ignored.
- Commands 00/01/10 never touch tx_valid or dout.

## Timing
- Reset values: tx_valid=0, dout=0, busy=0, write_add=0, read_add=0, remain=0, state=IDLE.
- Reset takes effect immediately (asynchronous); a burst interrupted by reset is abandoned and tx_valid drops without waiting for a clock.
- Write latency: mem updated at the edge that samples rx_valid with command 01.
- Read latency: command 11 sampled at edge N. busy=1 after edge N. tx_valid=1 with the first word after edge N+1.
- Burst throughput: one word per cycle while tx_ready stays high.
- Burst end: tx_valid and busy fall at the edge that samples tx_ready on the last word. The next command is accepted from the following edge.

## Configuration
- SPI_RAM_CLEAR_ON_RESET_EN defined: reset also zeroes every memory word. Registers the array as flops; the old clear-on-reset behaviour.
- Not defined: memory contents are untouched by reset, which allows block-RAM inference. Reading a never-written location returns undefined data, and benches must not check it.

## Structure
- Package spi_ram_pkg holds:
  - command encodings CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11;
  - FSM state encoding IDLE/FETCH/HOLD.
- One sub-module, spi_ram_mem:
  - DEPTH x DATA_WIDTH array with one write port and one registered read port;
  - the clear-on-reset macro is confined to it.
- spi_ram_ctrl holds the decode, the address pointers, the burst counter, the FSM and the handshake.

## Test plan
- Reset check: reset asserted mid-burst (tx_valid=1) -> tx_valid, busy and dout are 0 immediately. With the macro defined, reading address 0x00 afterwards returns 0.
- Auto-increment: 00/0x10, 01/0xA1, 01/0xB2, 01/0xC3, then 10/0x10, 11/0x00 three times, tx_ready=1 -> dout 0xA1, 0xB2, 0xC3.
- Burst with wrap: write 0x11 at 0xFF and 0x22 at 0x00; then 10/0xFF, 11/0x01, tx_ready=1 -> dout 0x11 then 0x22 on consecutive cycles. busy falls after the second word; read_add = 0x01.
- Backpressure: 4-word burst with tx_ready low for 3 cycles on word 2 -> word 2 held stable with tx_valid=1; no word is lost or duplicated.
- Command dropped while busy: 00/0x40 issued while busy=1 -> write_add unchanged. A following 01 (issued after busy=0) writes to the previous write_add.
- Parameters: ADDR_WIDTH=4, DATA_WIDTH=16; 16-word burst from 0x0 -> all 16 words returned in order, then read_add = 0x0.
